// File: rtl/hazard_pkg.sv
// ---------------------------------------------------------------------------
// hazard_pkg
// Shared definitions for the forwarding / load-use hazard unit.
//   fwd_sel_t  : EX-stage operand mux select encodings
//   tag_t      : per-stage pipeline tag {valid, rd, regwrite, memread}
//   TAG_BUBBLE : all-zero tag, used for bubbles and reset
//   tag_hit()  : true when a stage tag will write the given source register
// ---------------------------------------------------------------------------
package hazard_pkg;

    // The tag's rd field has a fixed width so the struct can live in the
    // package. Register indices narrower than this are zero-extended.
    localparam int RD_W_MAX = 8;

    typedef enum logic [1:0] {
        FWD_REG   = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_t;

    typedef struct packed {
        logic                valid;
        logic [RD_W_MAX-1:0] rd;
        logic                regwrite;
        logic                memread;
    } tag_t;

    localparam tag_t TAG_BUBBLE = '0;

    // Register 0 is hard-wired to zero, so it never counts as a producer.
    function automatic logic tag_hit(input tag_t t, input logic [RD_W_MAX-1:0] src);
        return t.valid && t.regwrite && (t.rd != '0) && (t.rd == src);
    endfunction

endpackage

// File: rtl/fwd_match.sv
// ---------------------------------------------------------------------------
// fwd_match
// Combinational forwarding-select for one EX-stage operand.
//   src     : source register index of the instruction about to enter EX
//   ex_tag  : tag of the instruction currently in EX (next edge: in MEM)
//   mem_tag : tag of the instruction currently in MEM (next edge: in WB)
//   sel     : FWD_EXMEM if EX produces src, else FWD_MEMWB if MEM does,
//             else FWD_REG. Never returns 2'b11.
// ---------------------------------------------------------------------------
module fwd_match
    import hazard_pkg::*;
(
    input  logic [RD_W_MAX-1:0] src,
    input  tag_t                ex_tag,
    input  tag_t                mem_tag,
    output logic [1:0]          sel
);

    // EX is the younger producer, so it is tested last and wins.
    always_comb begin
        sel = FWD_REG;
        if (tag_hit(mem_tag, src)) sel = FWD_MEMWB;
        if (tag_hit(ex_tag, src))  sel = FWD_EXMEM;
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// ---------------------------------------------------------------------------
// fwd_hazard_unit
// Forwarding selects and load-use stall detection for a 5-stage pipeline.
// Tracks EX/MEM/WB tags internally; the ID instruction's fields come in
// each cycle and are folded into EX on the rising edge.
//
// Ports
//   clk_i, rst_i            clock; synchronous active-high reset
//   id_valid_i              ID holds a real instruction
//   id_rs_i, id_rt_i        ID source registers
//   id_rd_i                 ID destination register
//   id_regwrite_i           ID instruction writes the register file
//   id_memread_i            ID instruction is a load
//   flush_i                 squash the ID instruction
//   stall_o                 hold PC and IF/ID this cycle (combinational)
//   fwd_a_sel_o/fwd_b_sel_o registered EX operand mux selects
//   stall_cnt_o             saturating count of load-use stall cycles
// ---------------------------------------------------------------------------
module fwd_hazard_unit
    import hazard_pkg::*;
#(
    parameter int REG_W = 5,   // must not exceed RD_W_MAX
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             id_valid_i,
    input  logic [REG_W-1:0] id_rs_i,
    input  logic [REG_W-1:0] id_rt_i,
    input  logic [REG_W-1:0] id_rd_i,
    input  logic             id_regwrite_i,
    input  logic             id_memread_i,
    input  logic             flush_i,
    output logic             stall_o,
    output logic [1:0]       fwd_a_sel_o,
    output logic [1:0]       fwd_b_sel_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    logic [RD_W_MAX-1:0] rs_ext;
    logic [RD_W_MAX-1:0] rt_ext;
    logic [RD_W_MAX-1:0] rd_ext;

    tag_t ex_q;
    tag_t mem_q;
    tag_t wb_q;
    tag_t ex_d;

    logic             load_bubble;
    logic [1:0]       fwd_a_d;
    logic [1:0]       fwd_b_d;
    logic [1:0]       fwd_a_q;
    logic [1:0]       fwd_b_q;
    logic [CNT_W-1:0] cnt_q;

    always_comb begin
        rs_ext = '0;
        rt_ext = '0;
        rd_ext = '0;
        rs_ext[REG_W-1:0] = id_rs_i;
        rt_ext[REG_W-1:0] = id_rt_i;
        rd_ext[REG_W-1:0] = id_rd_i;
    end

    // Load in EX whose result is needed by ID. Flush wins over stall, and
    // reset masks it so a stall in progress drops immediately.
    always_comb begin
        stall_o = !rst_i && id_valid_i && !flush_i &&
                  ex_q.valid && ex_q.memread && ex_q.regwrite &&
                  (ex_q.rd != '0) &&
                  ((ex_q.rd == rs_ext) || (ex_q.rd == rt_ext));
    end

    assign load_bubble = stall_o || flush_i || !id_valid_i;

    always_comb begin
        ex_d = TAG_BUBBLE;
        if (!load_bubble) begin
            ex_d.valid    = 1'b1;
            ex_d.rd       = rd_ext;
            ex_d.regwrite = id_regwrite_i;
            ex_d.memread  = id_memread_i;
        end
    end

    // Selects are computed against the current EX/MEM tags: after the edge
    // those producers sit in MEM and WB, matching the mux inputs.
    fwd_match u_match_rs (
        .src     (rs_ext),
        .ex_tag  (ex_q),
        .mem_tag (mem_q),
        .sel     (fwd_a_d)
    );

    fwd_match u_match_rt (
        .src     (rt_ext),
        .ex_tag  (ex_q),
        .mem_tag (mem_q),
        .sel     (fwd_b_d)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ex_q    <= TAG_BUBBLE;
            mem_q   <= TAG_BUBBLE;
            wb_q    <= TAG_BUBBLE;
            fwd_a_q <= FWD_REG;
            fwd_b_q <= FWD_REG;
            cnt_q   <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= ex_q;
            wb_q  <= mem_q;
            if (load_bubble) begin
                fwd_a_q <= FWD_REG;
                fwd_b_q <= FWD_REG;
            end else begin
                fwd_a_q <= fwd_a_d;
                fwd_b_q <= fwd_b_d;
            end
            if (stall_o && (cnt_q != '1)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    // The WB tag is kept for pipeline visibility only; same-cycle WB write
    // vs. ID read is resolved write-first inside the register file.
    logic unused_wb;
    assign unused_wb = ^wb_q;

    assign fwd_a_sel_o = fwd_a_q;
    assign fwd_b_sel_o = fwd_b_q;
    assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench: the driver applies one ID-stage vector per cycle and
// queues the hand-computed outputs expected in that cycle; the monitor pops
// one entry on each falling edge and compares. A second instance with a
// 2-bit counter shares the stimulus to observe saturation.
module tb_fwd_hazard_unit;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       id_valid_i;
    logic [4:0] id_rs_i;
    logic [4:0] id_rt_i;
    logic [4:0] id_rd_i;
    logic       id_regwrite_i;
    logic       id_memread_i;
    logic       flush_i;

    logic        stall_o,  stall_s;
    logic [1:0]  fa_o, fb_o, fa_s, fb_s;
    logic [15:0] cnt_o;
    logic [1:0]  cnt_s;

    always #5 clk_i = ~clk_i;

    fwd_hazard_unit u_dut (
        .clk_i(clk_i), .rst_i(rst_i), .id_valid_i(id_valid_i),
        .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_rd_i(id_rd_i),
        .id_regwrite_i(id_regwrite_i), .id_memread_i(id_memread_i),
        .flush_i(flush_i), .stall_o(stall_o),
        .fwd_a_sel_o(fa_o), .fwd_b_sel_o(fb_o), .stall_cnt_o(cnt_o)
    );

    fwd_hazard_unit #(.REG_W(5), .CNT_W(2)) u_sat (
        .clk_i(clk_i), .rst_i(rst_i), .id_valid_i(id_valid_i),
        .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_rd_i(id_rd_i),
        .id_regwrite_i(id_regwrite_i), .id_memread_i(id_memread_i),
        .flush_i(flush_i), .stall_o(stall_s),
        .fwd_a_sel_o(fa_s), .fwd_b_sel_o(fb_s), .stall_cnt_o(cnt_s)
    );

    typedef struct {
        string       name;
        logic        full;   // 0: only stall is defined this cycle
        logic        st;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [15:0] cnt;
        logic [1:0]  cnt2;
    } exp_t;

    exp_t exp_q[$];
    int   nvec  = 0;
    int   nfail = 0;

    task automatic step(input string nm, input logic v, input int rs, input int rt,
                        input int rd, input logic rw, input logic mr, input logic fl,
                        input logic rst, input logic full, input logic st,
                        input int fa, input int fb, input int cnt, input int cnt2);
        exp_t e;
        @(posedge clk_i);
        #1;
        rst_i         = rst;
        id_valid_i    = v;
        id_rs_i       = 5'(rs);
        id_rt_i       = 5'(rt);
        id_rd_i       = 5'(rd);
        id_regwrite_i = rw;
        id_memread_i  = mr;
        flush_i       = fl;
        e.name = nm; e.full = full; e.st = st;
        e.fa = 2'(fa); e.fb = 2'(fb); e.cnt = 16'(cnt); e.cnt2 = 2'(cnt2);
        exp_q.push_back(e);
    endtask

    task automatic nop(input string nm, input int fa, input int fb,
                       input int cnt, input int cnt2);
        step(nm, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, fa, fb, cnt, cnt2);
    endtask

    // Monitor
    always @(negedge clk_i) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            nvec++;
            if (stall_o !== e.st || stall_s !== e.st) begin
                nfail++;
                $display("FAIL %s stall: got %0b/%0b want %0b", e.name, stall_o, stall_s, e.st);
            end
            if (e.full) begin
                nvec++;
                if (fa_o !== e.fa) begin
                    nfail++;
                    $display("FAIL %s fwd_a: got %0d want %0d", e.name, fa_o, e.fa);
                end
                nvec++;
                if (fb_o !== e.fb) begin
                    nfail++;
                    $display("FAIL %s fwd_b: got %0d want %0d", e.name, fb_o, e.fb);
                end
                nvec++;
                if (cnt_o !== e.cnt) begin
                    nfail++;
                    $display("FAIL %s stall_cnt: got %0d want %0d", e.name, cnt_o, e.cnt);
                end
                nvec++;
                if (cnt_s !== e.cnt2) begin
                    nfail++;
                    $display("FAIL %s stall_cnt_w2: got %0d want %0d", e.name, cnt_s, e.cnt2);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_i = 1'b1; id_valid_i = 1'b0; id_rs_i = '0; id_rt_i = '0; id_rd_i = '0;
        id_regwrite_i = 1'b0; id_memread_i = 1'b0; flush_i = 1'b0;

        //   name        v rs rt rd rw mr fl rst full st fa fb cnt c2
        step("rst1",     0, 0, 0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0);
        step("rst2",     0, 0, 0, 0, 0, 0, 0, 1, 1,  0, 0, 0, 0, 0);

        // ALU back-to-back
        step("alu_add",  1, 1, 2, 3, 1, 0, 0, 0, 1,  0, 0, 0, 0, 0);
        step("alu_sub",  1, 3, 4, 6, 1, 0, 0, 0, 1,  0, 0, 0, 0, 0);
        nop ("alu_chk",  1, 0, 0, 0);

        // Distance 2, then EX and MEM both producing r5
        step("d2_add",   1, 1, 1, 5, 1, 0, 0, 0, 1,  0, 0, 0, 0, 0);
        nop ("d2_nop",   0, 0, 0, 0);
        step("d2_or",    1, 9, 5, 8, 1, 0, 0, 0, 1,  0, 0, 0, 0, 0);
        step("d2_chk",   1, 0, 0, 5, 1, 0, 0, 0, 1,  0, 0, 2, 0, 0);
        step("both_add", 1, 0, 0, 5, 1, 0, 0, 0, 1,  0, 0, 0, 0, 0);
        step("both_and", 1, 5, 5,10, 1, 0, 0, 0, 1,  0, 0, 0, 0, 0);
        nop ("both_chk", 1, 1, 0, 0);

        // Load-use: one stall, bubble, then MEM/WB forward
        step("lu_lw",    1, 1, 0, 7, 1, 1, 0, 0, 1,  0, 0, 0, 0, 0);
        step("lu_stall", 1, 7, 3, 8, 1, 0, 0, 0, 1,  1, 0, 0, 0, 0);
        step("lu_hold",  1, 7, 3, 8, 1, 0, 0, 0, 1,  0, 0, 0, 1, 1);
        nop ("lu_chk",   2, 0, 1, 1);

        // Register 0 never matches
        step("r0_lw",    1, 0, 0, 0, 1, 1, 0, 0, 1,  0, 0, 0, 1, 1);
        step("r0_add",   1, 0, 0, 9, 1, 0, 0, 0, 1,  0, 0, 0, 1, 1);
        nop ("r0_chk",   0, 0, 1, 1);

        // Flush beats load-use stall; flushed instruction becomes a bubble
        step("fl_lw",    1, 0, 0, 2, 1, 1, 0, 0, 1,  0, 0, 0, 1, 1);
        step("fl_beq",   1, 2, 0,12, 1, 0, 1, 0, 1,  0, 0, 0, 1, 1);
        step("fl_use",   1,12, 0,13, 1, 0, 0, 0, 1,  0, 0, 0, 1, 1);
        nop ("fl_chk",   0, 0, 1, 1);

        // Reset asserted while a load-use stall condition holds
        step("rs_lw",    1, 0, 0, 4, 1, 1, 0, 0, 1,  0, 0, 0, 1, 1);
        step("rs_mid",   1, 4, 0, 5, 1, 0, 0, 1, 1,  0, 0, 0, 1, 1);
        step("rs_after", 1, 4, 4, 6, 1, 0, 0, 0, 1,  0, 0, 0, 0, 0);
        nop ("rs_chk",   0, 0, 0, 0);

        // Five load-use stalls: 16-bit counter reaches 5, 2-bit saturates at 3
        for (int k = 0; k < 5; k++) begin
            step("sat_lw",    1, 0, 0, 7, 1, 1, 0, 0, 1, 0, (k == 0) ? 0 : 2, 0,
                 k, (k > 3) ? 3 : k);
            step("sat_stall", 1, 7, 0, 8, 1, 0, 0, 0, 1, 1, 0, 0,
                 k, (k > 3) ? 3 : k);
            step("sat_hold",  1, 7, 0, 8, 1, 0, 0, 0, 1, 0, 0, 0,
                 k + 1, (k + 1 > 3) ? 3 : k + 1);
        end
        nop("sat_chk", 2, 0, 5, 3);

        @(posedge clk_i);
        @(negedge clk_i);
        #1;
        if (exp_q.size() != 0) begin
            nvec++;
            nfail++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 SHALL have parameter REG_W, default 5, meaning register-index width.
REQ-002 SHALL have parameter CNT_W, default 16, meaning stall-counter width.
REQ-003 SHALL have port clk_i, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i, input, 1, meaning reset; synchronous, active-high.
REQ-005 SHALL have port id_valid_i, input, 1, meaning the ID stage holds a real instruction.
REQ-006 SHALL have ports id_rs_i and id_rt_i, input, REG_W each, meaning the ID-stage source registers.
REQ-007 SHALL have port id_rd_i, input, REG_W, meaning the ID-stage destination register.
REQ-008 SHALL have ports id_regwrite_i and id_memread_i, input, 1 each, meaning the ID instruction writes the register file and is a load.
REQ-009 SHALL have port flush_i, input, 1, meaning squash the ID instruction (taken branch or jump).
REQ-010 SHALL have port stall_o, output, 1, meaning hold PC and IF/ID this cycle.
REQ-011 SHALL have ports fwd_a_sel_o and fwd_b_sel_o, output, 2 each, meaning the select for the EX-stage 3-input operand muxes: 00 register file, 01 EX/MEM result, 10 MEM/WB result.
REQ-012 SHALL have port stall_cnt_o, output, CNT_W, meaning the number of load-use stall cycles since reset.

Function
REQ-013 SHALL keep internal tags for EX, MEM and WB: {valid, rd, regwrite, memread}.
REQ-014 SHALL compute stall_o combinationally = id_valid_i & !flush_i & EX.valid & EX.memread & EX.regwrite & (EX.rd != 0) & (EX.rd == id_rs_i | EX.rd == id_rt_i).
REQ-015 SHALL advance the tags every non-reset cycle: WB <= MEM, MEM <= EX, with no hold condition.
REQ-016 SHALL load EX with a bubble (all fields 0) when stall_o, flush_i or !id_valid_i; otherwise it SHALL load the ID fields.
REQ-017 SHALL register fwd_a_sel_o on the same edge as EX. Value 01 if current EX.valid & EX.regwrite & EX.rd != 0 & EX.rd == id_rs_i; else 10 if the same test passes on current MEM; else 00.
REQ-018 SHALL derive fwd_b_sel_o the same way from id_rt_i.
REQ-019 SHALL give EX priority (01) over MEM (10) when both match.
REQ-020 SHALL never match register 0.
REQ-021 SHALL force both selects to 00 on any edge where EX loads a bubble.
REQ-022 SHALL never output select value 11.
REQ-023 SHALL give a load-use pair exactly one stall cycle. The dependent instruction then enters EX with select 10.
REQ-024 SHALL give flush_i priority over stall when both conditions hold: stall_o=0, EX gets a bubble, and the counter does not increment.
REQ-025 SHALL increment stall_cnt_o by 1 on each edge where stall_o=1, saturating at all-ones with no wrap.
REQ-026 SHALL exclude the same-cycle WB-write/ID-read case from its scope; the register file resolves that case as write-first.

Reset
REQ-027 SHALL, on any edge with rst_i=1, clear all tags to bubble, set fwd_a_sel_o=fwd_b_sel_o=00, and set stall_cnt_o=0.
REQ-028 SHALL hold stall_o=0 while rst_i=1, including reset asserted mid-stall.
REQ-029 SHALL give no forwarding to an instruction issued before reset on the first cycle after reset.

Structure
REQ-030 SHALL place select encodings FWD_REG=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10 and the tag struct/bubble constant in shared package hazard_pkg.
REQ-031 SHALL use one sub-module, fwd_match, instantiated twice (rs, rt). It is combinational: it takes a source index and two tags and returns a 2-bit select.
REQ-032 SHALL drive the existing EX-stage 3-input operand mux selects directly from fwd_a_sel_o and fwd_b_sel_o.

Verification
REQ-033 SHALL check ALU back-to-back. Issue add rd=3, then sub rs=3 rt=4 -> second instruction in EX with fwd_a_sel_o=01, fwd_b_sel_o=00, stall_o never 1.
REQ-034 SHALL check distance-2. Issue add rd=5, nop, then or rt=5 -> fwd_b_sel_o=10. A rd=5 in both EX and MEM -> 01.
REQ-035 SHALL check load-use. Issue lw rd=7, then add rs=7 -> stall_o=1 for exactly one cycle, EX bubble, then fwd_a_sel_o=10, stall_cnt_o=1.
REQ-036 SHALL check register 0. Issue lw rd=0, then add rs=0 -> stall_o=0, selects 00.
REQ-037 SHALL check flush during a load-use. Issue lw rd=2, then beq rs=2 with flush_i=1 -> stall_o=0, bubble, stall_cnt_o unchanged.
REQ-038 SHALL check reset and saturation. Assert rst_i mid-stall -> outputs 00/0 next edge. Preload a counter with CNT_W=2 and run 5 stalls -> stall_cnt_o=3.
